// File: rtl/relay_decode.sv
// relay_decode -- receive end of the relay link.
//
// Recovers relay pulses from the serial relay line. Each event is one high
// pulse of nominally 64 clk cycles. The pulse width is measured on the
// synchronized line. A pulse whose width is inside [MIN_WIDTH, MAX_WIDTH]
// is accepted: it gives a one-cycle pulse_valid strobe and a data_out
// envelope of HOLD_BITS*BIT_PERIOD cycles. Any other pulse gives one error
// strobe.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   data_in      raw relay line, asynchronous to clk
//   data_out     regenerated envelope, high HOLD_BITS*BIT_PERIOD cycles per
//                accepted pulse (retriggered by back-to-back acceptances)
//   pulse_valid  one-cycle strobe per accepted pulse
//   error        one-cycle strobe per rejected pulse (too short or too long)
//   pulse_count  [15:0] saturating count of accepted pulses
//                (only present when RELAY_DECODE_COUNT_EN is defined)
//
// Optional feature macro: RELAY_DECODE_COUNT_EN
module relay_decode #(
  parameter int MIN_WIDTH  = 48,
  parameter int MAX_WIDTH  = 80,
  parameter int BIT_PERIOD = 16,
  parameter int HOLD_BITS  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_in,
  output logic        data_out,
  output logic        pulse_valid,
  output logic        error
`ifdef RELAY_DECODE_COUNT_EN
  ,
  output logic [15:0] pulse_count
`endif
);

  localparam logic [7:0] MIN_W     = 8'(MIN_WIDTH);
  localparam logic [7:0] MAX_W     = 8'(MAX_WIDTH);
  localparam logic [7:0] SAT_W     = 8'(MAX_WIDTH + 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_BITS * BIT_PERIOD);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  // Input conditioning
  logic       sync1_q;
  logic       sync2_q;
  logic       edge_q;
  logic [1:0] fill_q;
  logic       armed_q;
  logic       armed_d;
  logic       rise;

  // FSM and datapath
  state_t     state_q;
  state_t     state_d;
  logic [7:0] width_q;
  logic [7:0] width_d;
  logic [7:0] hold_q;
  logic [7:0] hold_d;
  logic       accept;
  logic       reject;
  logic       pulse_valid_q;
  logic       error_q;
  logic       data_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  // The synchronizer reads 0 out of reset. That value is a reset artefact,
  // not a real sample of the line. fill_q[1] marks that sync2_q holds a real
  // sample. Rises are honoured only after a real low has been seen. As a
  // result, a line that is still high when reset is released is not treated
  // as a new pulse.
  always_comb begin
    armed_d = armed_q | (fill_q[1] & ~sync2_q);
  end

  assign rise = sync2_q & ~edge_q & armed_q;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (width_q >= MAX_W) begin
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs (accept/reject strobes and the width counter update)
  always_comb begin
    accept  = 1'b0;
    reject  = 1'b0;
    width_d = width_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          width_d = 8'd1;
        end
      end
      MEASURE: begin
        if (!sync2_q) begin
          if ((width_q >= MIN_W) && (width_q <= MAX_W)) begin
            accept = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end else if (width_q >= MAX_W) begin
          // The next high cycle would exceed MAX_WIDTH. Reject now. The
          // remainder of the pulse is then ignored in WAIT_LOW, so the pulse
          // gives exactly one error strobe.
          reject  = 1'b1;
          width_d = SAT_W;
        end else begin
          width_d = width_q + 8'd1;
        end
      end
      default: begin
        width_d = width_q;
      end
    endcase
  end

  // Hold counter: independent of the FSM. An acceptance reloads the full
  // count, so back-to-back pulses give one continuous envelope.
  always_comb begin
    if (accept) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != 8'd0) begin
      hold_d = hold_q - 8'd1;
    end else begin
      hold_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_q       <= 8'd0;
      hold_q        <= 8'd0;
      pulse_valid_q <= 1'b0;
      error_q       <= 1'b0;
      data_out_q    <= 1'b0;
    end else begin
      width_q       <= width_d;
      hold_q        <= hold_d;
      pulse_valid_q <= accept;
      error_q       <= reject;
      data_out_q    <= (hold_d != 8'd0);
    end
  end

  assign pulse_valid = pulse_valid_q;
  assign error       = error_q;
  assign data_out    = data_out_q;

`ifdef RELAY_DECODE_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'd0;
    end else if (accept && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign pulse_count = count_q;
`endif

endmodule

// File: tb/tb_relay_decode.sv
// Testbench for relay_decode. A table of pulses is driven onto data_in.
// Each record gives the high and low widths and the expected classification.
// For every pulse, the strobe it must produce is pushed to a scoreboard
// together with the cycle in which it is due. A negedge monitor pops and
// compares each entry. The monitor also checks data_out against the envelope
// window that follows each expected acceptance.
module tb_relay_decode;

  localparam int MIN_WIDTH = 48;
  localparam int MAX_WIDTH = 80;
  localparam int HOLD      = 32;

  localparam int K_ACC   = 1;
  localparam int K_SHORT = 2;
  localparam int K_LONG  = 3;

  logic clk = 1'b0;
  logic reset;
  logic data_in;
  logic data_out;
  logic pulse_valid;
  logic error;
`ifdef RELAY_DECODE_COUNT_EN
  logic [15:0] pulse_count;
  int          exp_count = 0;
`endif

  int cyc      = 0;
  int checks   = 0;
  int errors   = 0;
  int do_until = 0;

  typedef struct {
    int   cyc;
    logic v;
    logic e;
  } exp_t;

  typedef struct {
    int high;
    int low;
    int kind;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t left_e;
  vec_t tbl[13];

  relay_decode dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .pulse_valid(pulse_valid),
    .error      (error)
`ifdef RELAY_DECODE_COUNT_EN
    ,
    .pulse_count(pulse_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int c, input logic v, input logic e);
    exp_t t;
    t.cyc = c;
    t.v   = v;
    t.e   = e;
    sb.push_back(t);
  endtask

  // Drives one pulse. It starts just after a posedge, so the first edge that
  // samples the line high is c0+1 and the first edge that samples it low is
  // c0+high+1. The strobe is due two edges later, at c0+high+3. An overlong
  // pulse is rejected when the measured width would reach MAX_WIDTH+1, that
  // is, at c0+MAX_WIDTH+3.
  task automatic drive_pulse(input int high, input int low, input int kind);
    int c0;
    c0 = cyc;
    data_in = 1'b1;
    if (kind == K_LONG) push_exp(c0 + MAX_WIDTH + 3, 1'b0, 1'b1);
    repeat (high) tick();
    data_in = 1'b0;
    if (kind == K_ACC) begin
      push_exp(c0 + high + 3, 1'b1, 1'b0);
`ifdef RELAY_DECODE_COUNT_EN
      exp_count++;
`endif
    end else if (kind == K_SHORT) begin
      push_exp(c0 + high + 3, 1'b0, 1'b1);
    end
    repeat (low) tick();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      do_until = 0;
    end else begin
      if ((sb.size() > 0) && (sb[0].cyc == cyc)) begin
        mon_e = sb.pop_front();
        check("pulse_valid", pulse_valid, mon_e.v);
        check("error", error, mon_e.e);
        if (mon_e.v) do_until = cyc + HOLD;
      end else if (pulse_valid || error) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe at cycle %0d: pulse_valid=%b error=%b, expected 0 0",
                 cyc, pulse_valid, error);
      end
      check("data_out", data_out, (cyc < do_until));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w;
    int k;

    tbl[0]  = '{high: 64,  low: 100, kind: K_ACC};
    tbl[1]  = '{high: 47,  low: 100, kind: K_SHORT};
    tbl[2]  = '{high: 48,  low: 100, kind: K_ACC};
    tbl[3]  = '{high: 80,  low: 100, kind: K_ACC};
    tbl[4]  = '{high: 81,  low: 100, kind: K_LONG};
    tbl[5]  = '{high: 300, low: 20,  kind: K_LONG};
    tbl[6]  = '{high: 64,  low: 100, kind: K_ACC};
    tbl[7]  = '{high: 64,  low: 8,   kind: K_ACC};
    tbl[8]  = '{high: 64,  low: 100, kind: K_ACC};
    tbl[9]  = '{high: 1,   low: 50,  kind: K_SHORT};
    tbl[10] = '{high: 2,   low: 50,  kind: K_SHORT};
    tbl[11] = '{high: 49,  low: 40,  kind: K_ACC};
    tbl[12] = '{high: 79,  low: 40,  kind: K_ACC};

    reset   = 1'b1;
    data_in = 1'b0;
    repeat (3) tick();
    check("reset_data_out", data_out, 1'b0);
    check("reset_pulse_valid", pulse_valid, 1'b0);
    check("reset_error", error, 1'b0);
    #2 reset = 1'b0;
    repeat (10) tick();

    for (int i = 0; i < 13; i++) begin
      drive_pulse(tbl[i].high, tbl[i].low, tbl[i].kind);
    end

    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(40, 90);
      if (w < MIN_WIDTH) k = K_SHORT;
      else if (w > MAX_WIDTH) k = K_LONG;
      else k = K_ACC;
      drive_pulse(w, 60, k);
    end

    // The previous envelope is still high when reset hits the next pulse.
    // That pulse is discarded, and the next clean pulse is accepted.
    drive_pulse(64, 2, K_ACC);
    data_in = 1'b1;
    repeat (30) tick();
    check("data_out_before_reset", data_out, 1'b1);
    #2 reset = 1'b1;
`ifdef RELAY_DECODE_COUNT_EN
    exp_count = 0;
`endif
    #1;
    check("async_reset_data_out", data_out, 1'b0);
    check("async_reset_pulse_valid", pulse_valid, 1'b0);
    check("async_reset_error", error, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (34) tick();
    data_in = 1'b0;
    repeat (100) tick();
    drive_pulse(64, 100, K_ACC);

    repeat (50) tick();
    while (sb.size() > 0) begin
      left_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_strobe due at cycle %0d: never observed, expected pulse_valid=%b error=%b",
               left_e.cyc, left_e.v, left_e.e);
    end

`ifdef RELAY_DECODE_COUNT_EN
    checks++;
    if (pulse_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL pulse_count: got %0d, expected %0d", pulse_count, exp_count);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
